riscv_multicycle_control: RTL

Multi-cycle control FSM for the RV32I core. It is the sequential successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state datapath strobes. It handshakes with instruction and data memory through a shared ready signal, traps on illegal opcodes or memory timeout, and counts retired instructions.

---
 rtl/riscv_pkg.sv | 57 +++++
 rtl/riscv_multicycle_control_if.sv | 39 +++
 rtl/riscv_multicycle_control_opcode_class.sv | 26 ++
 rtl/riscv_multicycle_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcodes,
// FSM state encoding, ALU operand selects and writeback selects.
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ASRC_RS1  = 2'b00,
        ASRC_PC   = 2'b01,
        ASRC_ZERO = 2'b10
    } alu_a_e;

    typedef enum logic [1:0] {
        BSRC_RS2  = 2'b00,
        BSRC_IMM  = 2'b01,
        BSRC_FOUR = 2'b10
    } alu_b_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    // One-hot instruction class; all-zero means the opcode is illegal.
    typedef struct packed {
        logic branch;
        logic load;
        logic store;
        logic rtype;
        logic iarith;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic fence;
    } opc_class_t;

endpackage

// File: rtl/riscv_multicycle_control_if.sv
// Control <-> datapath/memory bundle. The controller is the master: it
// consumes opcode, mem_ready and branch_taken and drives every strobe.
interface riscv_multicycle_control_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           opcode;
    logic                 mem_ready;
    logic                 branch_taken;

    logic                 ir_write;
    logic                 pc_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
    logic                 jump;
    logic                 jalr;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           wb_sel;
    logic                 illegal;
    logic                 mem_timeout;
    logic [INSTRET_W-1:0] instret;
    logic [2:0]           state;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output ir_write, pc_write, mem_read, mem_write, branch, jump, jalr,
               reg_write, alu_src_a, alu_src_b, wb_sel, illegal, mem_timeout,
               instret, state
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  ir_write, pc_write, mem_read, mem_write, branch, jump, jalr,
               reg_write, alu_src_a, alu_src_b, wb_sel, illegal, mem_timeout,
               instret, state
    );
endinterface

// File: rtl/riscv_multicycle_control_opcode_class.sv
// Combinational opcode -> one-hot class decode, shared by DECODE and EXEC.
module riscv_opcode_class
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output opc_class_t cls,
    output logic       legal
);

    // Exact-match each legal major opcode; anything else decodes to no class.
    always_comb begin
        cls        = '0;
        cls.branch = (opcode == OPC_BRANCH);
        cls.load   = (opcode == OPC_LOAD);
        cls.store  = (opcode == OPC_STORE);
        cls.rtype  = (opcode == OPC_RTYPE);
        cls.iarith = (opcode == OPC_IARITH);
        cls.lui    = (opcode == OPC_LUI);
        cls.auipc  = (opcode == OPC_AUIPC);
        cls.jal    = (opcode == OPC_JAL);
        cls.jalr   = (opcode == OPC_JALR);
        cls.fence  = (opcode == OPC_FENCE);
        legal      = |cls;
    end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait timeout, sticky trap causes and a retired-instruction counter.
module riscv_multicycle_control
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES      = 255,
    parameter int ENABLE_ILLEGAL_TRAP = 1,
    parameter int INSTRET_W           = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    riscv_multicycle_control_if.master bus
);

    // Counter only needs to reach TIMEOUT_CYCLES: at that value we either
    // trap or leave the state, and any state change clears it.
    localparam int              WAIT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam bit              TRAP_EN    = (ENABLE_ILLEGAL_TRAP != 0);

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 illegal_q, illegal_d;
    logic                 mem_timeout_q, mem_timeout_d;

    opc_class_t cls;
    logic       legal;
    logic       retire;
    logic       timeout_hit;

    logic    ir_write, pc_write, mem_read, mem_write;
    logic    branch, jump, jalr, reg_write;
    alu_a_e  alu_a;
    alu_b_e  alu_b;
    wb_sel_e wb_sel;

    riscv_opcode_class u_class (
        .opcode (bus.opcode),
        .cls    (cls),
        .legal  (legal)
    );

    // A late mem_ready always wins over the timeout in the same cycle.
    assign timeout_hit = TIMEOUT_EN && !bus.mem_ready && (wait_q == WAIT_LIMIT);

    // Next-state and per-state datapath strobes.
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        mem_timeout_d = mem_timeout_q;
        retire        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        jump          = 1'b0;
        jalr          = 1'b0;
        reg_write     = 1'b0;
        alu_a         = ASRC_RS1;
        alu_b         = BSRC_RS2;
        wb_sel        = WB_ALU;

        case (state_q)
            ST_FETCH: begin
                // ALU computes PC+4 while the instruction is read.
                mem_read = 1'b1;
                alu_a    = ASRC_PC;
                alu_b    = BSRC_FOUR;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout_hit) begin
                    mem_timeout_d = 1'b1;
                    state_d       = ST_TRAP;
                end
            end

            ST_DECODE: begin
                if (cls.fence) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (legal) begin
                    state_d = ST_EXEC;
                end else if (TRAP_EN) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    // Illegal opcode quietly retires as a NOP.
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end

            ST_EXEC: begin
                state_d = ST_WB;
                if (cls.rtype) begin
                    alu_b = BSRC_RS2;
                end else if (cls.iarith) begin
                    alu_b = BSRC_IMM;
                end else if (cls.lui) begin
                    alu_a = ASRC_ZERO;
                    alu_b = BSRC_IMM;
                end else if (cls.auipc) begin
                    alu_a = ASRC_PC;
                    alu_b = BSRC_IMM;
                end else if (cls.load || cls.store) begin
                    alu_b   = BSRC_IMM;
                    state_d = ST_MEM;
                end else if (cls.branch) begin
                    branch   = 1'b1;
                    pc_write = bus.branch_taken;
                    state_d  = ST_FETCH;
                    retire   = 1'b1;
                end else if (cls.jal) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                    alu_a    = ASRC_PC;
                    alu_b    = BSRC_IMM;
                end else if (cls.jalr) begin
                    jalr     = 1'b1;
                    pc_write = 1'b1;
                    alu_b    = BSRC_IMM;
                end else begin
                    // Unreachable while the IR is held; recover without retiring.
                    state_d = ST_FETCH;
                end
            end

            ST_MEM: begin
                mem_read  = cls.load;
                mem_write = cls.store;
                if (bus.mem_ready) begin
                    state_d = cls.load ? ST_WB : ST_FETCH;
                    retire  = cls.store;
                end else if (timeout_hit) begin
                    mem_timeout_d = 1'b1;
                    state_d       = ST_TRAP;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                if (cls.load)                wb_sel = WB_MEM;
                else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
                else                         wb_sel = WB_ALU;
                state_d = ST_FETCH;
                retire  = 1'b1;
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Retire counter and memory wait counter updates.
    always_comb begin
        instret_d = instret_q + INSTRET_W'(retire);
        wait_d    = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (TIMEOUT_EN && !bus.mem_ready &&
                     (state_q == ST_FETCH || state_q == ST_MEM)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State, counters and sticky flags; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            wait_q        <= '0;
            instret_q     <= '0;
            illegal_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            instret_q     <= instret_d;
            illegal_q     <= illegal_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Every output is held low while rst is asserted, even before the edge.
    always_comb begin
        bus.ir_write    = ir_write  & ~rst;
        bus.pc_write    = pc_write  & ~rst;
        bus.mem_read    = mem_read  & ~rst;
        bus.mem_write   = mem_write & ~rst;
        bus.branch      = branch    & ~rst;
        bus.jump        = jump      & ~rst;
        bus.jalr        = jalr      & ~rst;
        bus.reg_write   = reg_write & ~rst;
        bus.alu_src_a   = rst ? 2'b00 : alu_a;
        bus.alu_src_b   = rst ? 2'b00 : alu_b;
        bus.wb_sel      = rst ? 2'b00 : wb_sel;
        bus.illegal     = illegal_q     & ~rst;
        bus.mem_timeout = mem_timeout_q & ~rst;
        bus.instret     = rst ? '0 : instret_q;
        bus.state       = rst ? ST_FETCH : state_q;
    end

endmodule
